// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MEM stage: FSM state encoding, exception codes
// latched alongside an instruction, and the datapath width.
package mem_stage_pkg;

    localparam int DATA_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    localparam logic [1:0] EXC_NONE     = 2'd0;
    localparam logic [1:0] EXC_MISALIGN = 2'd1;
    localparam logic [1:0] EXC_BUS      = 2'd2;
    localparam logic [1:0] EXC_OVERFLOW = 2'd3;

    // Exactly one of read/write selects a memory access; both together is a NOP.
    function automatic logic is_mem_op(input logic mem_read, input logic mem_write);
        return mem_read ^ mem_write;
    endfunction

endpackage

// File: rtl/mem_req_ctrl.sv
// Data-memory request controller: raises dmem_req on start, holds the request
// fields stable until dmem_ack, and gives up after TIMEOUT request cycles.
// done/timeout are single-cycle strobes seen in the last request cycle.
module mem_req_ctrl
    import mem_stage_pkg::*;
#(
    parameter int ADDR_W  = 10,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              start_we,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [DATA_W-1:0] start_wdata,
    input  logic              dmem_ack,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    output logic              done,
    output logic              timeout
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] wait_cnt;

    // An ack in the final allowed cycle beats the timeout.
    assign done    = dmem_req & dmem_ack;
    assign timeout = dmem_req & ~dmem_ack & (wait_cnt == CNT_LAST);

    // Request register, held fields and wait counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= '0;
            dmem_wdata <= '0;
            wait_cnt   <= '0;
        end else if (start) begin
            dmem_req   <= 1'b1;
            dmem_we    <= start_we;
            dmem_addr  <= start_addr;
            dmem_wdata <= start_wdata;
            wait_cnt   <= '0;
        end else if (dmem_req) begin
            if (done || timeout) begin
                dmem_req <= 1'b0;
                wait_cnt <= '0;
            end else begin
                wait_cnt <= wait_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/mem_stage.sv
// MEM stage of the 5-stage MIPS core. Latches the EX bundle, performs LW/SW
// over a req/ack bus with timeout, and emits a one-cycle writeback bundle.
// Optional feature macro: OVERFLOW_TRAP_EN adds exc_overflow and suppresses
// the register write of overflowing ADD/SUB/ADDI results.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int ADDR_W  = 10,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_overflow,
    input  logic              is_arith,
    input  logic [DATA_W-1:0] rt_data,
    input  logic [4:0]        rd_addr,
    input  logic              reg_write,
    input  logic              mem_read,
    input  logic              mem_write,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic              dmem_ack,
    input  logic [DATA_W-1:0] dmem_rdata,
    output logic              wb_valid,
    output logic              wb_reg_write,
    output logic [4:0]        wb_rd,
    output logic [DATA_W-1:0] wb_data,
    output logic              exc_misalign,
`ifdef OVERFLOW_TRAP_EN
    output logic              exc_overflow,
`endif
    output logic              exc_bus
);

    state_t            state;
    logic              transfer;
    logic              is_mem;
    logic              misaligned;
    logic              start;
    logic              ovf_hit;
    logic              req_done;
    logic              req_timeout;

    logic [4:0]        lat_rd;
    logic              lat_reg_write;
    logic              lat_is_lw;
    logic [DATA_W-1:0] lat_data;
    logic [1:0]        lat_exc;

    assign in_ready   = (state == ST_IDLE);
    assign transfer   = in_valid & in_ready;
    assign is_mem     = is_mem_op(mem_read, mem_write);
    assign misaligned = is_mem & (alu_result[1:0] != 2'b00);
    assign start      = transfer & is_mem & ~misaligned;

`ifdef OVERFLOW_TRAP_EN
    assign ovf_hit = is_arith & alu_overflow;
`else
    logic unused_ovf;
    assign unused_ovf = is_arith & alu_overflow;
    assign ovf_hit    = 1'b0;
`endif

    mem_req_ctrl #(
        .ADDR_W  (ADDR_W),
        .TIMEOUT (TIMEOUT)
    ) u_req_ctrl (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .start_we    (mem_write),
        .start_addr  (alu_result[ADDR_W+1:2]),
        .start_wdata (rt_data),
        .dmem_ack    (dmem_ack),
        .dmem_req    (dmem_req),
        .dmem_we     (dmem_we),
        .dmem_addr   (dmem_addr),
        .dmem_wdata  (dmem_wdata),
        .done        (req_done),
        .timeout     (req_timeout)
    );

    // Stage FSM: latch on accept, wait for the bus, then pulse the writeback bundle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            lat_rd        <= '0;
            lat_reg_write <= 1'b0;
            lat_is_lw     <= 1'b0;
            lat_data      <= '0;
            lat_exc       <= EXC_NONE;
            wb_valid      <= 1'b0;
            wb_reg_write  <= 1'b0;
            wb_rd         <= '0;
            wb_data       <= '0;
            exc_misalign  <= 1'b0;
            exc_bus       <= 1'b0;
`ifdef OVERFLOW_TRAP_EN
            exc_overflow  <= 1'b0;
`endif
        end else begin
            wb_valid     <= 1'b0;
            wb_reg_write <= 1'b0;
            exc_misalign <= 1'b0;
            exc_bus      <= 1'b0;
`ifdef OVERFLOW_TRAP_EN
            exc_overflow <= 1'b0;
`endif
            case (state)
                ST_IDLE: begin
                    if (transfer) begin
                        lat_rd        <= rd_addr;
                        lat_reg_write <= reg_write & ~(mem_write & ~mem_read);
                        lat_is_lw     <= mem_read & ~mem_write;
                        lat_data      <= alu_result;
                        if (misaligned) begin
                            lat_exc <= EXC_MISALIGN;
                        end else if (ovf_hit) begin
                            lat_exc <= EXC_OVERFLOW;
                        end else begin
                            lat_exc <= EXC_NONE;
                        end
                        state <= start ? ST_ACCESS : ST_DONE;
                    end
                end
                ST_ACCESS: begin
                    if (req_done) begin
                        if (lat_is_lw) begin
                            lat_data <= dmem_rdata;
                        end
                        state <= ST_DONE;
                    end else if (req_timeout) begin
                        lat_exc <= EXC_BUS;
                        state   <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    wb_valid     <= 1'b1;
                    wb_rd        <= lat_rd;
                    wb_data      <= lat_data;
                    wb_reg_write <= lat_reg_write & (lat_rd != 5'd0) & (lat_exc == EXC_NONE);
                    exc_misalign <= (lat_exc == EXC_MISALIGN);
                    exc_bus      <= (lat_exc == EXC_BUS);
`ifdef OVERFLOW_TRAP_EN
                    exc_overflow <= (lat_exc == EXC_OVERFLOW);
`endif
                    state        <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed spec scenarios, then randomized
// instructions with a randomized memory responder. Expected writebacks and
// their cycles are computed at accept time from the stage's timing rules.
module tb_mem_stage;

    localparam int ADDR_W  = 10;
    localparam int TIMEOUT = 15;
    localparam int NO_ACK  = 1000;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [31:0]       alu_result;
    logic              alu_overflow;
    logic              is_arith;
    logic [31:0]       rt_data;
    logic [4:0]        rd_addr;
    logic              reg_write;
    logic              mem_read;
    logic              mem_write;
    logic              dmem_req;
    logic              dmem_we;
    logic [ADDR_W-1:0] dmem_addr;
    logic [31:0]       dmem_wdata;
    logic              dmem_ack;
    logic [31:0]       dmem_rdata;
    logic              wb_valid;
    logic              wb_reg_write;
    logic [4:0]        wb_rd;
    logic [31:0]       wb_data;
    logic              exc_misalign;
    logic              exc_bus;
`ifdef OVERFLOW_TRAP_EN
    logic              exc_overflow;
`endif

    typedef struct {
        int          cyc;
        logic        rw;
        logic [4:0]  rd;
        logic [31:0] data;
        logic        chk_data;
        logic        misal;
        logic        bus;
        logic        ovf;
    } wb_exp_t;

    wb_exp_t exp_q[$];
    wb_exp_t cur;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    bit compare_en = 0;
    bit reset_seen = 0;

    // Memory job handed from the driver to the responder.
    bit                mem_pending = 0;
    int                mem_lat;
    logic [31:0]       mem_rdat;
    logic              mem_we_exp;
    logic [ADDR_W-1:0] mem_addr_exp;
    logic [31:0]       mem_wdata_exp;

    // Observations used by the literal pin checks.
    int          last_accept_cyc;
    int          last_wb_cyc;
    logic [31:0] last_wb_data;
    logic        last_rw;
    logic        last_misal;
    logic        last_bus;
    logic        last_ovf;
    logic [ADDR_W-1:0] last_req_addr;
    logic        last_req_we;
    int          last_req_cycles;
    int          req_starts = 0;

    mem_stage #(
        .ADDR_W  (ADDR_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .alu_result   (alu_result),
        .alu_overflow (alu_overflow),
        .is_arith     (is_arith),
        .rt_data      (rt_data),
        .rd_addr      (rd_addr),
        .reg_write    (reg_write),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .dmem_req     (dmem_req),
        .dmem_we      (dmem_we),
        .dmem_addr    (dmem_addr),
        .dmem_wdata   (dmem_wdata),
        .dmem_ack     (dmem_ack),
        .dmem_rdata   (dmem_rdata),
        .wb_valid     (wb_valid),
        .wb_reg_write (wb_reg_write),
        .wb_rd        (wb_rd),
        .wb_data      (wb_data),
        .exc_misalign (exc_misalign),
`ifdef OVERFLOW_TRAP_EN
        .exc_overflow (exc_overflow),
`endif
        .exc_bus      (exc_bus)
    );

    // Free-running clock and cycle index.
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // Drive one instruction, wait for acceptance and queue its predicted writeback.
    task automatic applyStimulus(input logic [31:0] res, input logic ovf, input logic arith,
                                 input logic [4:0] rd, input logic rw, input logic mr,
                                 input logic mw, input int lat, input logic [31:0] rdat);
        logic [31:0] rt;
        int waited;
        bit acc;
        bit is_mem;
        bit misal;
        bit trap;
        wb_exp_t e;
        rt = $urandom;
        @(posedge clk);
        #1;
        in_valid = 1'b1; alu_result = res; alu_overflow = ovf; is_arith = arith;
        rt_data = rt; rd_addr = rd; reg_write = rw; mem_read = mr; mem_write = mw;
        waited = 0;
        acc = 0;
        while (!acc && waited < 100) begin
            @(negedge clk);
            acc = in_ready;
            waited++;
        end
        #1;
        if (!acc) begin
            checks++;
            errors++;
            $display("[TB] FAIL accept: in_ready never rose within 100 cycles, expected acceptance");
        end else begin
            is_mem = mr ^ mw;
            misal  = is_mem && (res[1:0] != 2'b00);
`ifdef OVERFLOW_TRAP_EN
            trap   = arith && ovf;
`else
            trap   = 0;
`endif
            e.misal    = misal;
            e.bus      = is_mem && !misal && (lat >= TIMEOUT);
            e.ovf      = trap;
            e.rd       = rd;
            e.rw       = rw && (rd != 5'd0) && !(mw && !mr) && !(e.misal || e.bus || e.ovf);
            e.data     = (mr && !mw) ? rdat : res;
            e.chk_data = !(e.misal || e.bus);
            if (!is_mem || misal)     e.cyc = cyc + 2;
            else if (lat < TIMEOUT)   e.cyc = cyc + 3 + lat;
            else                      e.cyc = cyc + TIMEOUT + 2;
            exp_q.push_back(e);
            last_accept_cyc = cyc;
            if (is_mem && !misal) begin
                mem_pending   = 1;
                mem_lat       = lat;
                mem_rdat      = rdat;
                mem_we_exp    = mw;
                mem_addr_exp  = res[ADDR_W+1:2];
                mem_wdata_exp = rt;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        alu_result = $urandom;
        rt_data = $urandom;
        rd_addr = 5'($urandom);
        mem_read = 1'($urandom);
        mem_write = 1'($urandom);
    endtask

    task automatic waitIdle();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL wait_idle: %0d writebacks outstanding, expected 0", exp_q.size());
            exp_q.delete();
        end
        @(negedge clk);
        #2;
    endtask

    // Compare process: in_ready and the writeback bundle against the prediction queue.
    always @(negedge clk) begin
        if (rst_n && compare_en) begin
            automatic bit due = (exp_q.size() > 0) && (exp_q[0].cyc == cyc);
            automatic bit exp_ready = (exp_q.size() == 0) || (exp_q[0].cyc == cyc);
            checkOutput("in_ready", {31'b0, in_ready}, {31'b0, exp_ready});
            checkOutput("wb_valid", {31'b0, wb_valid}, {31'b0, due});
            if (due) begin
                cur = exp_q.pop_front();
                if (wb_valid) begin
                    checkOutput("wb_reg_write", {31'b0, wb_reg_write}, {31'b0, cur.rw});
                    checkOutput("wb_rd", {27'b0, wb_rd}, {27'b0, cur.rd});
                    if (cur.chk_data) checkOutput("wb_data", wb_data, cur.data);
                    checkOutput("exc_misalign", {31'b0, exc_misalign}, {31'b0, cur.misal});
                    checkOutput("exc_bus", {31'b0, exc_bus}, {31'b0, cur.bus});
`ifdef OVERFLOW_TRAP_EN
                    checkOutput("exc_overflow", {31'b0, exc_overflow}, {31'b0, cur.ovf});
                    last_ovf = exc_overflow;
`else
                    last_ovf = 1'b0;
`endif
                    last_wb_cyc  = cyc;
                    last_wb_data = wb_data;
                    last_rw      = wb_reg_write;
                    last_misal   = exc_misalign;
                    last_bus     = exc_bus;
                end
            end
        end
    end

    // Memory responder: acks after the chosen latency and checks the request fields.
    initial begin
        bit busy;
        bit acked;
        int k;
        int req_cycles;
        int exp_cycles;
        busy = 0; acked = 0; k = 0; req_cycles = 0; exp_cycles = 0;
        dmem_ack = 1'b0;
        dmem_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            dmem_ack = 1'b0;
            dmem_rdata = $urandom;
            if (busy && (!dmem_req || acked)) begin
                checkOutput("req_drop", {31'b0, dmem_req}, 32'd0);
                if (!reset_seen) checkOutput("req_high_cycles", 32'(req_cycles), 32'(exp_cycles));
                last_req_cycles = req_cycles;
                busy = 0;
            end
            if (!busy && dmem_req && rst_n) begin
                checkOutput("req_expected", {31'b0, mem_pending}, 32'd1);
                busy = 1; acked = 0; k = 0; req_cycles = 0;
                exp_cycles = (mem_lat < TIMEOUT) ? mem_lat + 1 : TIMEOUT;
                mem_pending = 0;
                req_starts++;
                last_req_addr = dmem_addr;
                last_req_we = dmem_we;
            end
            if (busy && dmem_req) begin
                req_cycles++;
                checkOutput("dmem_we", {31'b0, dmem_we}, {31'b0, mem_we_exp});
                checkOutput("dmem_addr", 32'(dmem_addr), 32'(mem_addr_exp));
                if (mem_we_exp) checkOutput("dmem_wdata", dmem_wdata, mem_wdata_exp);
                if (k == mem_lat) begin
                    dmem_ack = 1'b1;
                    dmem_rdata = mem_rdat;
                    acked = 1;
                end
                k++;
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #800000;
        $display("[TB] FAIL watchdog: simulation still running, expected completion");
        $fatal(1);
    end

    // Main sequence: reset, directed scenarios, random traffic, reset during access.
    initial begin
        int starts0;
        int kind;
        int r;
        int lat;
        logic [31:0] res;
        logic mr;
        logic mw;
        rst_n = 1'b0;
        in_valid = 0; alu_result = 0; alu_overflow = 0; is_arith = 0; rt_data = 0;
        rd_addr = 0; reg_write = 0; mem_read = 0; mem_write = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_dmem_req", {31'b0, dmem_req}, 32'd0);
        checkOutput("rst_dmem_we", {31'b0, dmem_we}, 32'd0);
        checkOutput("rst_dmem_addr", 32'(dmem_addr), 32'd0);
        checkOutput("rst_dmem_wdata", dmem_wdata, 32'd0);
        checkOutput("rst_wb_valid", {31'b0, wb_valid}, 32'd0);
        checkOutput("rst_wb_reg_write", {31'b0, wb_reg_write}, 32'd0);
        checkOutput("rst_wb_data", wb_data, 32'd0);
        checkOutput("rst_wb_rd", {27'b0, wb_rd}, 32'd0);
        checkOutput("rst_exc", {30'b0, exc_misalign, exc_bus}, 32'd0);
        rst_n = 1'b1;
        compare_en = 1;
        $display("[TB] reset released");

        applyStimulus(32'h0000_0010, 0, 1, 5'd5, 1, 0, 0, 0, 0);
        waitIdle();
        checkOutput("add_wb_data", last_wb_data, 32'h10);
        checkOutput("add_latency", 32'(last_wb_cyc - last_accept_cyc), 32'd2);
        checkOutput("add_reg_write", {31'b0, last_rw}, 32'd1);

        applyStimulus(32'h0000_0008, 0, 0, 5'd7, 1, 1, 0, 3, 32'hDEAD_BEEF);
        waitIdle();
        checkOutput("lw_addr", 32'(last_req_addr), 32'd2);
        checkOutput("lw_we", {31'b0, last_req_we}, 32'd0);
        checkOutput("lw_wb_data", last_wb_data, 32'hDEAD_BEEF);
        checkOutput("lw_latency", 32'(last_wb_cyc - last_accept_cyc), 32'd6);

        starts0 = req_starts;
        applyStimulus(32'h0000_0006, 0, 0, 5'd9, 0, 0, 1, 0, 0);
        waitIdle();
        checkOutput("sw_misal_req", 32'(req_starts - starts0), 32'd0);
        checkOutput("sw_misal_exc", {31'b0, last_misal}, 32'd1);
        checkOutput("sw_misal_rw", {31'b0, last_rw}, 32'd0);

        applyStimulus(32'h0000_0040, 0, 0, 5'd3, 0, 0, 1, NO_ACK, 0);
        waitIdle();
        checkOutput("sw_to_req_cycles", 32'(last_req_cycles), 32'(TIMEOUT));
        checkOutput("sw_to_exc_bus", {31'b0, last_bus}, 32'd1);
        checkOutput("sw_to_latency", 32'(last_wb_cyc - last_accept_cyc), 32'(TIMEOUT + 2));

        applyStimulus(32'h0000_0104, 0, 0, 5'd11, 1, 1, 0, TIMEOUT - 1, 32'h1234_5678);
        waitIdle();
        checkOutput("lw_edge_exc_bus", {31'b0, last_bus}, 32'd0);
        checkOutput("lw_edge_data", last_wb_data, 32'h1234_5678);
        checkOutput("lw_edge_rw", {31'b0, last_rw}, 32'd1);

        applyStimulus(32'h0000_ABCD, 0, 0, 5'd0, 1, 0, 0, 0, 0);
        waitIdle();
        checkOutput("rd0_rw", {31'b0, last_rw}, 32'd0);

        starts0 = req_starts;
        applyStimulus(32'h0000_0013, 0, 0, 5'd2, 1, 1, 1, 0, 0);
        waitIdle();
        checkOutput("nop_req", 32'(req_starts - starts0), 32'd0);
        checkOutput("nop_rw", {31'b0, last_rw}, 32'd1);

        applyStimulus(32'h8000_0000, 1, 1, 5'd4, 1, 0, 0, 0, 0);
        waitIdle();
`ifdef OVERFLOW_TRAP_EN
        checkOutput("ovf_exc", {31'b0, last_ovf}, 32'd1);
        checkOutput("ovf_rw", {31'b0, last_rw}, 32'd0);
`else
        checkOutput("ovf_wrap_rw", {31'b0, last_rw}, 32'd1);
        checkOutput("ovf_wrap_data", last_wb_data, 32'h8000_0000);
`endif

        for (int i = 0; i < 300; i++) begin
            kind = $urandom_range(0, 9);
            r = $urandom_range(0, 9);
            if (r < 7)       lat = $urandom_range(0, 4);
            else if (r == 7) lat = TIMEOUT - 1;
            else if (r == 8) lat = TIMEOUT;
            else             lat = NO_ACK;
            res = $urandom;
            mr = 0;
            mw = 0;
            if (kind <= 3) begin
                mr = 0; mw = 0;
            end else if (kind <= 5) begin
                mr = 1; res[1:0] = 2'b00;
            end else if (kind <= 7) begin
                mw = 1; res[1:0] = 2'b00;
            end else if (kind == 8) begin
                mr = 1'($urandom);
                mw = ~mr;
                res[1:0] = 2'($urandom_range(1, 3));
            end else begin
                mr = 1; mw = 1;
            end
            applyStimulus(res, 1'($urandom), (kind <= 3) ? 1'($urandom) : 1'b0,
                          5'($urandom), 1'($urandom), mr, mw, lat, $urandom);
        end
        waitIdle();
        $display("[TB] random phase done");

        applyStimulus(32'h0000_0100, 0, 0, 5'd1, 0, 0, 1, NO_ACK, 0);
        @(posedge clk);
        #2;
        reset_seen = 1;
        compare_en = 0;
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        checkOutput("rst_mid_req", {31'b0, dmem_req}, 32'd0);
        checkOutput("rst_mid_wb_valid", {31'b0, wb_valid}, 32'd0);
        @(negedge clk);
        mem_pending = 0;
        rst_n = 1'b1;
        compare_en = 1;
        repeat (20) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
